// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: pipelined carry-lookahead adder/subtractor built from
// 4-bit CLA blocks, BLOCKS_PER_STAGE blocks resolved per clock.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     operand beat handshake (a_in, b_in, c_in, sub)
//   out_valid/out_ready   result handshake (s_out, c_out, ovf_out)
//   sub=1 computes a_in - b_in; c_out=1 then means no borrow.
module pipelined_cla_adder #(
   parameter int NUMBITS          = 16,
   parameter int BLOCKS_PER_STAGE = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [NUMBITS-1:0] a_in,
   input  logic [NUMBITS-1:0] b_in,
   input  logic               c_in,
   input  logic               sub,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [NUMBITS-1:0] s_out,
   output logic               c_out,
   output logic               ovf_out
);

   localparam int NBLK = NUMBITS / 4;
   localparam int BPS  = BLOCKS_PER_STAGE;
   localparam int BPSS = (BPS < 1) ? 1 : BPS;
   localparam int LAT  = (NBLK / BPSS < 1) ? 1 : NBLK / BPSS;

   generate
      if ((NUMBITS % 4) != 0 || NUMBITS < 4) begin : g_bad_width
         $error("NUMBITS must be a positive multiple of 4");
      end
      if (BPS < 1 || (NBLK % BPSS) != 0) begin : g_bad_bps
         $error("BLOCKS_PER_STAGE must divide NUMBITS/4");
      end
   endgenerate

   // Returns {carry into bit 3, carry out, sum[3:0]}.
   function automatic logic [5:0] cla4(
      input logic [3:0] a,
      input logic [3:0] b,
      input logic       ci
   );
      logic [3:0] g;
      logic [3:0] p;
      logic [4:0] c;
      g    = a & b;
      p    = a ^ b;
      c[0] = ci;
      c[1] = g[0] | (p[0] & ci);
      c[2] = g[1] | (p[1] & g[0])
           | (p[1] & p[0] & ci);
      c[3] = g[2] | (p[2] & g[1])
           | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & ci);
      c[4] = g[3] | (p[3] & g[2])
           | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & ci);
      return {c[3], c[4], p ^ c[3:0]};
   endfunction

   // Stage k register: result of stage k logic.
   // r_s holds the sum bits done so far; r_a/r_b
   // keep the operands for the blocks still to go.
   logic [NUMBITS-1:0] r_a   [LAT];
   logic [NUMBITS-1:0] r_b   [LAT];
   logic [NUMBITS-1:0] r_s   [LAT];
   logic               r_sub [LAT];
   logic               r_c   [LAT];
   logic               r_cm  [LAT];
   logic               r_vld [LAT];

   logic [NUMBITS-1:0] w_a   [LAT];
   logic [NUMBITS-1:0] w_b   [LAT];
   logic [NUMBITS-1:0] w_s   [LAT];
   logic               w_sub [LAT];
   logic               w_c   [LAT];
   logic               w_cm  [LAT];
   logic               w_vld [LAT];

   logic [5:0]         w_blk;
   logic [3:0]         w_bs;
   logic               w_cc;
   logic               w_adv;

   // One global enable: the whole pipe moves or
   // holds together, so stalled outputs stay put.
   assign w_adv     = !r_vld[LAT-1] || out_ready;
   assign in_ready  = w_adv;
   assign out_valid = r_vld[LAT-1];
   assign s_out     = r_s[LAT-1];
   assign c_out     = r_c[LAT-1];
   assign ovf_out   = r_cm[LAT-1] ^ r_c[LAT-1];

   always_comb begin
      w_blk = '0;
      w_bs  = '0;
      w_cc  = 1'b0;
      for (int k = 0; k < LAT; k++) begin
         if (k == 0) begin
            w_a[k]   = a_in;
            w_b[k]   = b_in;
            w_s[k]   = '0;
            w_sub[k] = sub;
            w_vld[k] = in_valid;
            // Subtract forces carry-in to 1.
            w_cc     = sub | c_in;
            w_cm[k]  = 1'b0;
         end else begin
            w_a[k]   = r_a[(k > 0) ? k - 1 : 0];
            w_b[k]   = r_b[(k > 0) ? k - 1 : 0];
            w_s[k]   = r_s[(k > 0) ? k - 1 : 0];
            w_sub[k] = r_sub[(k > 0) ? k - 1 : 0];
            w_vld[k] = r_vld[(k > 0) ? k - 1 : 0];
            w_cc     = r_c[(k > 0) ? k - 1 : 0];
            w_cm[k]  = r_cm[(k > 0) ? k - 1 : 0];
         end
         for (int j = 0; j < BPSS; j++) begin
            w_bs  = w_b[k][(k*BPSS+j)*4 +: 4]
                  ^ {4{w_sub[k]}};
            w_blk = cla4(w_a[k][(k*BPSS+j)*4 +: 4],
                         w_bs, w_cc);
            w_s[k][(k*BPSS+j)*4 +: 4] = w_blk[3:0];
            w_cc    = w_blk[4];
            // Last block of the last stage owns
            // the MSB, so this ends up as c_msb_in.
            w_cm[k] = w_blk[5];
         end
         w_c[k] = w_cc;
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < LAT; k++) begin
         if (!rst_n) begin
            r_vld[k] <= 1'b0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_s[k]   <= '0;
            r_sub[k] <= 1'b0;
            r_c[k]   <= 1'b0;
            r_cm[k]  <= 1'b0;
         end else if (w_adv) begin
            r_vld[k] <= w_vld[k];
            r_a[k]   <= w_a[k];
            r_b[k]   <= w_b[k];
            r_s[k]   <= w_s[k];
            r_sub[k] <= w_sub[k];
            r_c[k]   <= w_c[k];
            r_cm[k]  <= w_cm[k];
         end
      end
   end

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: drives three adder configurations
// (16/1, 32/2, 32/8) and checks them against an arithmetic model.
module tb_pipelined_cla_adder;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [31:0] a [3];
   logic [31:0] b [3];
   logic        cin [3];
   logic        sb [3];
   logic        iv [3];
   logic        ordy [3];
   logic        ir [3];
   logic        ov [3];
   logic        co [3];
   logic        of [3];
   logic [15:0] s0;
   logic [31:0] s1;
   logic [31:0] s2;

   int W [3] = '{16, 32, 32};
   int L [3] = '{4, 4, 1};

   logic [33:0] q0 [$];
   logic [33:0] q1 [$];
   logic [33:0] q2 [$];

   int checks = 0;
   int failures = 0;
   bit in_rst = 1'b1;
   bit acc [3];

   pipelined_cla_adder #(.NUMBITS(16), .BLOCKS_PER_STAGE(1)) u_d0 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[0]), .in_ready(ir[0]),
      .a_in(a[0][15:0]), .b_in(b[0][15:0]),
      .c_in(cin[0]), .sub(sb[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]),
      .s_out(s0), .c_out(co[0]), .ovf_out(of[0]));

   pipelined_cla_adder #(.NUMBITS(32), .BLOCKS_PER_STAGE(2)) u_d1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[1]), .in_ready(ir[1]),
      .a_in(a[1]), .b_in(b[1]),
      .c_in(cin[1]), .sub(sb[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]),
      .s_out(s1), .c_out(co[1]), .ovf_out(of[1]));

   pipelined_cla_adder #(.NUMBITS(32), .BLOCKS_PER_STAGE(8)) u_d2 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(iv[2]), .in_ready(ir[2]),
      .a_in(a[2]), .b_in(b[2]),
      .c_in(cin[2]), .sub(sb[2]),
      .out_valid(ov[2]), .out_ready(ordy[2]),
      .s_out(s2), .c_out(co[2]), .ovf_out(of[2]));

   task automatic chk(string tag, logic [33:0] got,
                      logic [33:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] sget(int d);
      case (d)
         0:       return {16'd0, s0};
         1:       return s1;
         default: return s2;
      endcase
   endfunction

   // Model: {ovf, c_out, sum} from plain arithmetic;
   // overflow from operand/result signs.
   function automatic logic [33:0] ref_add(
      int w, logic [31:0] av, logic [31:0] bv,
      logic ci, logic sbv);
      logic [63:0] m, aa, bb, sum;
      logic c, o;
      m   = (64'd1 << w) - 64'd1;
      aa  = {32'd0, av} & m;
      bb  = (sbv ? ~{32'd0, bv} : {32'd0, bv}) & m;
      sum = aa + bb + (sbv ? 64'd1 : {63'd0, ci});
      c   = sum[w];
      o   = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
      return {o, c, sum[31:0] & m[31:0]};
   endfunction

   task automatic qpush(int d, logic [33:0] v);
      case (d)
         0:       q0.push_back(v);
         1:       q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endtask

   function automatic int qsz(int d);
      case (d)
         0:       return q0.size();
         1:       return q1.size();
         default: return q2.size();
      endcase
   endfunction

   task automatic qpop(int d, output logic [33:0] v);
      case (d)
         0:       v = q0.pop_front();
         1:       v = q1.pop_front();
         default: v = q2.pop_front();
      endcase
   endtask

   task automatic idle_all();
      for (int d = 0; d < 3; d++) begin
         iv[d]   = 1'b0;
         ordy[d] = 1'b1;
         a[d]    = '0;
         b[d]    = '0;
         cin[d]  = 1'b0;
         sb[d]   = 1'b0;
      end
   endtask

   task automatic rand_data(int d);
      a[d]   = $urandom;
      b[d]   = $urandom;
      if (W[d] == 16) begin
         a[d] = a[d] & 32'hFFFF;
         b[d] = b[d] & 32'hFFFF;
      end
      cin[d] = 1'($urandom);
      sb[d]  = 1'($urandom);
   endtask

   // Called at a negedge with inputs set; checks the
   // handshake due at the next posedge, then advances.
   task automatic tick();
      logic [33:0] prev [3];
      logic [33:0] e;
      bit held [3];
      #1;
      for (int d = 0; d < 3; d++) begin
         held[d] = ov[d] && !ordy[d];
         prev[d] = {of[d], co[d], sget(d)};
         acc[d]  = 1'b0;
         if (!in_rst) begin
            chk($sformatf("in_ready%0d", d),
                34'(ir[d]), 34'(!ov[d] || ordy[d]));
            if (ov[d] && ordy[d]) begin
               if (qsz(d) == 0)
                  chk($sformatf("spurious%0d", d),
                      34'(ov[d]), 34'd0);
               else begin
                  qpop(d, e);
                  chk($sformatf("result%0d", d), prev[d], e);
               end
            end
            if (iv[d] && ir[d]) begin
               acc[d] = 1'b1;
               qpush(d, ref_add(W[d], a[d], b[d],
                                cin[d], sb[d]));
            end
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (!in_rst) begin
         for (int d = 0; d < 3; d++) begin
            if (held[d]) begin
               chk($sformatf("stall_ov%0d", d),
                   34'(ov[d]), 34'd1);
               chk($sformatf("stall_data%0d", d),
                   {of[d], co[d], sget(d)}, prev[d]);
            end
         end
      end
   endtask

   task automatic drain();
      idle_all();
      for (int i = 0; i < 12; i++) tick();
      for (int d = 0; d < 3; d++)
         chk($sformatf("drain%0d", d), 34'(qsz(d)), 34'd0);
   endtask

   // Single beat into an empty pipe: latency and
   // fixed expected result.
   task automatic directed(int d, logic [31:0] av,
      logic [31:0] bv, logic ci, logic sbv,
      logic [31:0] es, logic ec, logic eo);
      int n;
      idle_all();
      a[d] = av; b[d] = bv; cin[d] = ci; sb[d] = sbv;
      iv[d] = 1'b1;
      tick();
      idle_all();
      n = 1;
      while (!ov[d] && n < 16) begin
         tick();
         n++;
      end
      chk($sformatf("latency%0d", d), 34'(n), 34'(L[d]));
      chk($sformatf("dir_s%0d", d), 34'(sget(d)), 34'(es));
      chk($sformatf("dir_c%0d", d), 34'(co[d]), 34'(ec));
      chk($sformatf("dir_ovf%0d", d), 34'(of[d]), 34'(eo));
      tick();
   endtask

   initial begin
      logic [31:0] all, msb;
      int sent [3];
      idle_all();
      in_rst = 1'b1;
      rst_n  = 1'b0;
      @(negedge clk);

      // Reset with random inputs toggling.
      for (int i = 0; i < 3; i++) begin
         for (int d = 0; d < 3; d++) begin
            rand_data(d);
            iv[d]   = 1'($urandom);
            ordy[d] = 1'($urandom);
         end
         tick();
      end
      #1;
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("rst_ov%0d", d), 34'(ov[d]), 34'd0);
         chk($sformatf("rst_s%0d", d), 34'(sget(d)), 34'd0);
         chk($sformatf("rst_c%0d", d), 34'(co[d]), 34'd0);
         chk($sformatf("rst_ovf%0d", d), 34'(of[d]), 34'd0);
         chk($sformatf("rst_rdy%0d", d), 34'(ir[d]), 34'd1);
      end
      rst_n  = 1'b1;
      in_rst = 1'b0;
      idle_all();

      // Directed vectors on every configuration.
      for (int d = 0; d < 3; d++) begin
         all = (W[d] == 16) ? 32'hFFFF : 32'hFFFF_FFFF;
         msb = (W[d] == 16) ? 32'h8000 : 32'h8000_0000;
         directed(d, 32'h1234, 32'h0FF0, 1'b1, 1'b0,
                  32'h2225, 1'b0, 1'b0);
         directed(d, all, 32'h0, 1'b1, 1'b0,
                  32'h0, 1'b1, 1'b0);
         directed(d, msb, 32'h1, 1'b1, 1'b1,
                  msb - 32'd1, 1'b1, 1'b1);
         directed(d, 32'h3, 32'h5, 1'b1, 1'b1,
                  all - 32'd1, 1'b0, 1'b0);
      end
      drain();

      // Backpressure: 8 beats, out_ready 1,0,0,...
      for (int d = 0; d < 3; d++) sent[d] = 0;
      for (int cyc = 0; cyc < 200; cyc++) begin
         if (sent[0] >= 8 && sent[1] >= 8 && sent[2] >= 8)
            break;
         for (int d = 0; d < 3; d++) begin
            ordy[d] = (cyc % 3) == 0;
            iv[d]   = sent[d] < 8;
            rand_data(d);
         end
         tick();
         for (int d = 0; d < 3; d++)
            if (acc[d]) sent[d]++;
      end
      for (int d = 0; d < 3; d++)
         chk($sformatf("bp_sent%0d", d), 34'(sent[d]), 34'd8);
      drain();

      // Random traffic with random backpressure.
      for (int cyc = 0; cyc < 400; cyc++) begin
         for (int d = 0; d < 3; d++) begin
            rand_data(d);
            iv[d]   = ($urandom % 4) != 0;
            ordy[d] = ($urandom % 3) != 0;
         end
         tick();
      end
      drain();

      // Reset with three beats in flight.
      for (int i = 0; i < 3; i++) begin
         for (int d = 0; d < 3; d++) begin
            rand_data(d);
            iv[d]   = 1'b1;
            ordy[d] = 1'b0;
         end
         tick();
      end
      idle_all();
      in_rst = 1'b1;
      rst_n  = 1'b0;
      tick();
      rst_n  = 1'b1;
      in_rst = 1'b0;
      q0.delete();
      q1.delete();
      q2.delete();
      for (int i = 0; i < 6; i++) begin
         tick();
         for (int d = 0; d < 3; d++)
            chk($sformatf("no_emit%0d", d), 34'(ov[d]), 34'd0);
      end
      for (int d = 0; d < 3; d++)
         directed(d, 32'h1234, 32'h0FF0, 1'b1, 1'b0,
                  32'h2225, 1'b0, 1'b0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d",
               checks, failures);
      $finish;
   end

endmodule
